// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one single-port memory between the fetch and data ports
// Data port wins arbitration; a starvation counter forces a fetch grant once
// STARVE_MAX consecutive data grants have been made while a fetch was pending.
module unified_mem_arbiter #(
  parameter int AW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic [31:0]   dm_rdata,
  output logic          dm_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          stallf,
  output logic          stallm
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // WAIT counts down from MEM_LAT-1; capture happens on the edge where it is 0.
  localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t        state_q, state_d;
  logic          owner_dm_q, owner_dm_d;   // 1 = data port owns the transaction
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    starve_q, starve_d;
  logic [2:0]    lat_q, lat_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic          if_ready_q, if_ready_d;
  logic          dm_ready_q, dm_ready_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;

  logic          fetch_forced;

  // A pending fetch that has watched STARVE_MAX data grants in a row overrides data priority.
  assign fetch_forced = if_req && (starve_q == STARVE_LIM);

  // Next-state, arbitration, capture and registered-output computation.
  always_comb begin
    state_d    = state_q;
    owner_dm_d = owner_dm_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    starve_d   = starve_q;
    lat_d      = lat_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    if_ready_d = 1'b0;
    dm_ready_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (dm_req && !fetch_forced) begin
          owner_dm_d = 1'b1;
          addr_d     = dm_addr;
          we_d       = dm_we;
          wdata_d    = dm_wdata;
          mem_en_d   = 1'b1;
          mem_we_d   = dm_we;
          state_d    = ISSUE;
          if (!if_req) begin
            starve_d = 4'd0;
          end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 4'd1;
          end
        end else if (if_req) begin
          owner_dm_d = 1'b0;
          addr_d     = if_addr;
          we_d       = 1'b0;
          wdata_d    = 32'd0;
          mem_en_d   = 1'b1;
          state_d    = ISSUE;
          starve_d   = 4'd0;
        end else begin
          starve_d = 4'd0;
        end
      end
      ISSUE: begin
        lat_d   = LAT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == 3'd0) begin
          if (owner_dm_q) begin
            if (!we_q) begin
              dm_rdata_d = mem_rdata;
            end
            dm_ready_d = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end
          state_d = RESP;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops mem_en and both ready pulses immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_dm_q <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      starve_q   <= 4'd0;
      lat_q      <= 3'd0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      if_rdata_q <= 32'd0;
      dm_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      owner_dm_q <= owner_dm_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      starve_q   <= starve_d;
      lat_q      <= lat_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      if_ready_q <= if_ready_d;
      dm_ready_q <= dm_ready_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

  // Stalls follow the raw requests until the matching ready pulse.
  assign stallf = if_req & ~if_ready_q;
  assign stallm = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - self-checking bench for unified_mem_arbiter
// Two instances share every input: A with MEM_LAT=1, B with MEM_LAT=2.
module tb_unified_mem_arbiter;
  localparam int AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;

  logic [31:0]   a_if_rdata, a_dm_rdata, a_mem_wdata, a_mem_rdata;
  logic          a_if_ready, a_dm_ready, a_mem_en, a_mem_we, a_stallf, a_stallm;
  logic [AW-1:0] a_mem_addr;
  logic [31:0]   b_if_rdata, b_dm_rdata, b_mem_wdata, b_mem_rdata;
  logic          b_if_ready, b_dm_ready, b_mem_en, b_mem_we, b_stallf, b_stallm;
  logic [AW-1:0] b_mem_addr;

  unified_mem_arbiter #(.AW(AW), .MEM_LAT(1), .STARVE_MAX(4)) dut_a (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(a_if_rdata), .if_ready(a_if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(a_dm_rdata), .dm_ready(a_dm_ready),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .stallf(a_stallf), .stallm(a_stallm)
  );

  unified_mem_arbiter #(.AW(AW), .MEM_LAT(2), .STARVE_MAX(4)) dut_b (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(b_dm_rdata), .dm_ready(b_dm_ready),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .stallf(b_stallf), .stallm(b_stallm)
  );

  // RAM models: sample mem_en at an edge, data valid MEM_LAT edges later.
  logic [31:0] ram_a [0:255];
  logic [31:0] ram_b [0:255];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b0, pipe_b1;
  logic        ld_en;
  logic [7:0]  ld_idx;
  logic [31:0] ld_data;

  always @(posedge clk) begin
    if (ld_en) ram_a[ld_idx] <= ld_data;
    else if (a_mem_en && a_mem_we) ram_a[a_mem_addr[9:2]] <= a_mem_wdata;
    if (a_mem_en) pipe_a <= ram_a[a_mem_addr[9:2]];
  end

  always @(posedge clk) begin
    if (ld_en) ram_b[ld_idx] <= ld_data;
    else if (b_mem_en && b_mem_we) ram_b[b_mem_addr[9:2]] <= b_mem_wdata;
    if (b_mem_en) pipe_b0 <= ram_b[b_mem_addr[9:2]];
    pipe_b1 <= pipe_b0;
  end

  assign a_mem_rdata = pipe_a;
  assign b_mem_rdata = pipe_b1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    if_req = 1'b0;
    dm_req = 1'b0;
    for (int i = 0; i < 12; i++) step();
  endtask

  typedef struct {
    logic        fetch;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [0:6];

  // One transaction on both instances; inputs are scrambled after acceptance.
  task automatic run_txn(input int idx);
    vec_t v;
    int a_en, b_en, a_rdy, b_rdy, stall_bad, wrong_rdy;
    logic [31:0] a_addr, b_addr, a_wd, a_rd, b_rd;
    logic a_we;
    v = vecs[idx];
    a_en = 0; b_en = 0; a_rdy = 0; b_rdy = 0; stall_bad = 0; wrong_rdy = 0;
    a_addr = '0; b_addr = '0; a_wd = '0; a_rd = '0; b_rd = '0; a_we = 1'b0;
    if_req = v.fetch; if_addr = v.addr;
    dm_req = ~v.fetch; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    for (int n = 1; n <= 16 && b_rdy == 0; n++) begin
      step();
      if (a_mem_en) begin a_en++; a_addr = a_mem_addr; a_we = a_mem_we; a_wd = a_mem_wdata; end
      if (b_mem_en) begin b_en++; b_addr = b_mem_addr; end
      if (a_stallf !== (if_req & ~a_if_ready) || a_stallm !== (dm_req & ~a_dm_ready)) stall_bad++;
      if (b_stallf !== (if_req & ~b_if_ready) || b_stallm !== (dm_req & ~b_dm_ready)) stall_bad++;
      if (a_rdy == 0 && (v.fetch ? a_if_ready : a_dm_ready)) begin
        a_rdy = n; a_rd = v.fetch ? a_if_rdata : a_dm_rdata;
      end
      if (b_rdy == 0 && (v.fetch ? b_if_ready : b_dm_ready)) begin
        b_rdy = n; b_rd = v.fetch ? b_if_rdata : b_dm_rdata;
      end
      if (v.fetch ? (a_dm_ready | b_dm_ready) : (a_if_ready | b_if_ready)) wrong_rdy++;
      if (n == 1) begin
        if_addr = 32'h3FC; dm_addr = 32'h3FC; dm_wdata = 32'hBAD0BAD0; dm_we = ~v.we;
      end
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    step();
    chk($sformatf("v%0d a_latency", idx), a_rdy, 32'd3);
    chk($sformatf("v%0d b_latency", idx), b_rdy, 32'd4);
    chk($sformatf("v%0d a_mem_en_cycles", idx), a_en, 32'd1);
    chk($sformatf("v%0d b_mem_en_cycles", idx), b_en, 32'd1);
    chk($sformatf("v%0d a_mem_addr", idx), a_addr, v.addr);
    chk($sformatf("v%0d b_mem_addr", idx), b_addr, v.addr);
    chk($sformatf("v%0d a_mem_we", idx), {31'd0, a_we}, {31'd0, v.we});
    if (v.we) chk($sformatf("v%0d a_mem_wdata", idx), a_wd, v.wdata);
    chk($sformatf("v%0d a_rdata", idx), a_rd, v.exp_rdata);
    chk($sformatf("v%0d b_rdata", idx), b_rd, v.exp_rdata);
    chk($sformatf("v%0d stall_mismatches", idx), stall_bad, 32'd0);
    chk($sformatf("v%0d wrong_port_ready", idx), wrong_rdy, 32'd0);
    chk($sformatf("v%0d ready_pulse_ends", idx),
        {28'd0, a_if_ready, a_dm_ready, b_if_ready, b_dm_ready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d_at, i_at, en_a, en_b, rdy_a, rdy_b, na, nb;
    logic [31:0] dr, ir, wr;
    logic [9:0] order_a, order_b;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h2008_0005};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0044, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0000_0000, 32'h1234_5678};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h2008_0005};

    reset = 1'b1;
    if_req = 1'b1; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    ld_en = 1'b1; ld_idx = 8'd0; ld_data = 32'h2008_0005;
    step();
    ld_en = 1'b0;
    step();

    // Reset state, stalls follow raw requests
    chk("rst a_mem_en", {31'd0, a_mem_en}, 32'd0);
    chk("rst a_mem_we", {31'd0, a_mem_we}, 32'd0);
    chk("rst a_mem_addr", a_mem_addr, 32'd0);
    chk("rst a_mem_wdata", a_mem_wdata, 32'd0);
    chk("rst readies", {30'd0, a_if_ready, a_dm_ready}, 32'd0);
    chk("rst a_if_rdata", a_if_rdata, 32'd0);
    chk("rst a_dm_rdata", a_dm_rdata, 32'd0);
    chk("rst a_stallf", {31'd0, a_stallf}, 32'd1);
    chk("rst a_stallm", {31'd0, a_stallm}, 32'd0);
    if_req = 1'b0;
    #2 reset = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_txn(i);
    settle();

    // Simultaneous requests: data first, fetch at the first IDLE edge after data RESP
    d_at = 0; i_at = 0; dr = '0; ir = '0;
    if_req = 1'b1; if_addr = 32'h0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    for (int n = 1; n <= 20 && (if_req || dm_req); n++) begin
      step();
      if (a_mem_en && a_mem_addr == 32'h40 && d_at == 0) d_at = n;
      if (a_mem_en && a_mem_addr == 32'h0 && i_at == 0) i_at = n;
      if (a_dm_ready && dm_req) begin dr = a_dm_rdata; dm_req = 1'b0; end
      if (a_if_ready && if_req) begin ir = a_if_rdata; if_req = 1'b0; end
    end
    chk("simul data_grant_cycle", d_at, 32'd1);
    chk("simul fetch_grant_cycle", i_at, 32'd5);
    chk("simul dm_rdata", dr, 32'hDEAD_BEEF);
    chk("simul if_rdata", ir, 32'h2008_0005);
    settle();

    // Withdrawal right after acceptance
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    step();
    dm_req = 1'b0;
    en_a = a_mem_en; en_b = b_mem_en; rdy_a = 0; rdy_b = 0; wr = '0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (a_mem_en) en_a++;
      if (b_mem_en) en_b++;
      if (a_dm_ready) begin rdy_a++; wr = a_dm_rdata; end
      if (b_dm_ready) rdy_b++;
    end
    chk("withdraw a_mem_en_cycles", en_a, 32'd1);
    chk("withdraw b_mem_en_cycles", en_b, 32'd1);
    chk("withdraw a_ready_pulses", rdy_a, 32'd1);
    chk("withdraw b_ready_pulses", rdy_b, 32'd1);
    chk("withdraw a_dm_rdata", wr, 32'hDEAD_BEEF);
    settle();

    // Contention: both held high, grant order D,D,D,D,I,D,D,D,D,I (bit set = fetch)
    na = 0; nb = 0; order_a = '0; order_b = '0;
    if_req = 1'b1; if_addr = 32'h100;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    for (int n = 0; n < 80 && (na < 10 || nb < 10); n++) begin
      step();
      if (a_mem_en && na < 10) begin order_a[na] = (a_mem_addr == 32'h100); na++; end
      if (b_mem_en && nb < 10) begin order_b[nb] = (b_mem_addr == 32'h100); nb++; end
    end
    chk("contend a_grants", na, 32'd10);
    chk("contend a_order", {22'd0, order_a}, 32'b10_0001_0000);
    chk("contend b_order", {22'd0, order_b}, 32'b10_0001_0000);
    settle();

    // Reset during ISSUE: mem_en drops without a clock edge, no ready afterwards
    if_req = 1'b1; if_addr = 32'h0;
    step();
    chk("midrst pre a_mem_en", {31'd0, a_mem_en}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst mem_en", {30'd0, a_mem_en, b_mem_en}, 32'd0);
    chk("midrst readies", {28'd0, a_if_ready, a_dm_ready, b_if_ready, b_dm_ready}, 32'd0);
    chk("midrst a_stallf", {31'd0, a_stallf}, 32'd1);
    if_req = 1'b0;
    #3 reset = 1'b0;
    en_a = 0; rdy_a = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (a_mem_en || b_mem_en) en_a++;
      if (a_if_ready || a_dm_ready || b_if_ready || b_dm_ready) rdy_a++;
    end
    chk("postrst mem_en_cycles", en_a, 32'd0);
    chk("postrst ready_pulses", rdy_a, 32'd0);
    chk("postrst a_stallf", {31'd0, a_stallf}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
